// File: rtl/fetch_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_controller_pkg
// Description : Shared types and constants for the instruction fetch path.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_controller_pkg;

   localparam int InsnAddrPath = 32;
   localparam int InsnDataPath = 32;
   localparam logic [InsnAddrPath-1:0] INSN_RESET_VECTOR = '0;

   typedef enum logic [2:0] {
      RESET_SYNC = 3'd0,
      ISSUE      = 3'd1,
      WAIT       = 3'd2,
      HOLD       = 3'd3,
      DRAIN      = 3'd4
   } FetchState;

   typedef struct packed {
      logic                    valid;
      logic [InsnAddrPath-1:0] addr;
   } FetchReq;

   typedef struct packed {
      logic                    valid;
      logic [InsnDataPath-1:0] data;
   } FetchRsp;

   // States in which a memory response is outstanding.
   function automatic logic isWaiting(input FetchState s);
      return (s == WAIT) || (s == DRAIN);
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module      : fetch_timeout_counter
// Description : Saturating wait counter with clear and a sticky expiry flag.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_timeout_counter #(
   parameter int unsigned LIMIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic countEn,
   input  logic countClr,
   output logic expired
);

   localparam int CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
   localparam logic [CNT_W-1:0] c_limit = CNT_W'(LIMIT);

   logic [CNT_W-1:0] r_count;
   logic             r_expired;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count   <= '0;
         r_expired <= 1'b0;
      end else begin
         if (countClr)
            r_count <= '0;
         else if (countEn && (r_count != c_limit))
            r_count <= r_count + 1'b1;
         // Flag rises on the edge where the count reaches the limit.
         if (countEn && !countClr && (r_count == c_limit - 1'b1))
            r_expired <= 1'b1;
      end
   end

   assign expired = r_expired;

endmodule
`default_nettype wire

// File: rtl/fetch_controller.sv
`default_nettype none
// ============================================================================
// Module      : fetch_controller
// Description : PC sequencing and single-outstanding instruction fetch to decode.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_controller
   import fetch_controller_pkg::*;
#(
   parameter int                    ADDR_WIDTH     = InsnAddrPath,
   parameter int                    INSN_WIDTH     = InsnDataPath,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR   = INSN_RESET_VECTOR,
   parameter int unsigned           TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] pcIn,
   output logic                  pcWrEnable,
   output logic [ADDR_WIDTH-1:0] pcWrAddr,
   output logic                  imemReq,
   output logic [ADDR_WIDTH-1:0] imemAddr,
   input  logic                  imemReady,
   input  logic                  imemValid,
   input  logic [INSN_WIDTH-1:0] imemData,
   output logic                  insnValid,
   output logic [INSN_WIDTH-1:0] insnOut,
   output logic [ADDR_WIDTH-1:0] insnAddr,
   input  logic                  stall,
   input  logic                  redirectValid,
   input  logic [ADDR_WIDTH-1:0] redirectAddr,
   output logic [31:0]           fetchCount,
   output logic                  timeoutErr
);

   FetchState             r_state;
   FetchState             w_state;
   FetchState             w_nextState;
   logic [ADDR_WIDTH-1:0] r_reqAddr;
   logic                  r_insnValid;
   logic [INSN_WIDTH-1:0] r_insnOut;
   logic [ADDR_WIDTH-1:0] r_insnAddr;
   logic [31:0]           r_fetchCount;

   FetchReq               w_req;
   FetchRsp               w_rsp;
   logic                  w_pcWrEnable;
   logic [ADDR_WIDTH-1:0] w_pcWrAddr;
   logic                  w_latchReq;
   logic                  w_capture;
   logic                  w_consume;
   logic                  w_dropInsn;
   logic                  w_waiting;

   // Reset forces the reset-vector behaviour immediately, so no request leaks out.
   assign w_state = rst ? RESET_SYNC : r_state;
   assign w_rsp   = '{valid: imemValid, data: imemData};

   always_comb begin
      w_nextState  = w_state;
      w_pcWrEnable = 1'b1;
      w_pcWrAddr   = pcIn;
      w_req        = '{valid: 1'b0, addr: pcIn};
      w_latchReq   = 1'b0;
      w_capture    = 1'b0;
      w_consume    = 1'b0;
      w_dropInsn   = 1'b0;
      case (w_state)
         RESET_SYNC: begin
            w_pcWrAddr  = RESET_VECTOR;
            w_nextState = ISSUE;
         end
         ISSUE: begin
            w_req.valid = 1'b1;
            if (imemReady) begin
               w_pcWrEnable = 1'b0;
               w_latchReq   = 1'b1;
               w_nextState  = WAIT;
            end
            if (redirectValid) begin
               w_pcWrEnable = 1'b1;
               w_pcWrAddr   = redirectAddr;
               w_nextState  = imemReady ? DRAIN : ISSUE;
            end
         end
         WAIT: begin
            if (redirectValid) begin
               w_pcWrAddr  = redirectAddr;
               w_nextState = w_rsp.valid ? ISSUE : DRAIN;
            end else if (w_rsp.valid) begin
               w_capture   = 1'b1;
               w_nextState = HOLD;
            end
         end
         HOLD: begin
            // A redirect wins over a same-cycle consume.
            if (redirectValid) begin
               w_pcWrAddr  = redirectAddr;
               w_dropInsn  = 1'b1;
               w_nextState = ISSUE;
            end else if (!stall) begin
               w_consume   = 1'b1;
               w_nextState = ISSUE;
            end
         end
         DRAIN: begin
            if (redirectValid)
               w_pcWrAddr = redirectAddr;
            if (w_rsp.valid)
               w_nextState = ISSUE;
         end
         default: w_nextState = RESET_SYNC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= RESET_SYNC;
         r_reqAddr    <= '0;
         r_insnValid  <= 1'b0;
         r_insnOut    <= '0;
         r_insnAddr   <= '0;
         r_fetchCount <= '0;
      end else begin
         r_state <= w_nextState;
         if (w_latchReq)
            r_reqAddr <= pcIn;
         if (w_capture) begin
            r_insnValid <= 1'b1;
            r_insnOut   <= w_rsp.data;
            r_insnAddr  <= r_reqAddr;
         end else if (w_consume || w_dropInsn) begin
            r_insnValid <= 1'b0;
         end
         if (w_consume)
            r_fetchCount <= r_fetchCount + 32'd1;
      end
   end

   assign w_waiting = isWaiting(r_state);

   fetch_timeout_counter #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk      (clk),
      .rst      (rst),
      .countEn  (w_waiting),
      .countClr (!w_waiting),
      .expired  (timeoutErr)
   );

   assign pcWrEnable = w_pcWrEnable;
   assign pcWrAddr   = w_pcWrAddr;
   assign imemReq    = w_req.valid;
   assign imemAddr   = w_req.addr;
   assign insnValid  = r_insnValid;
   assign insnOut    = r_insnOut;
   assign insnAddr   = r_insnAddr;
   assign fetchCount = r_fetchCount;

endmodule
`default_nettype wire
